// File: rtl/width_8to12_sched_pkg.sv
// Shared types and the round-robin pick helper for the 8-to-12 converter scheduler.
package width_conv_pkg;
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [1:0] PHASE_LAST = 2'd2;
  localparam int         MAX_CH     = 4;
  localparam int         IDX_W      = 2;

  // First set request at ptr, ptr+1, ... (mod n); the highest offset is visited first
  // so the lowest offset overwrites it and wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                               input logic [IDX_W-1:0]  ptr,
                                               input int                n);
    int               idx;
    logic [MAX_CH-1:0] sh;
    rr_pick = ptr;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        sh  = req >> idx;
        if (sh[0]) rr_pick = IDX_W'(idx);
      end
    end
  endfunction
endpackage

// File: rtl/width_8to12_sched_if.sv
// Requester, converter-drive and tag signals of the 8-to-12 scheduler.
interface width_8to12_sched_if #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0]      s_valid;
    logic [NUM_CH-1:0][7:0] s_data;
    logic [NUM_CH-1:0]      s_ready;
    logic                   conv_valid;
    logic [7:0]             conv_data;
    logic                   tag_valid;
    logic [CH_W-1:0]        tag_ch;
    logic                   busy;

    modport master (output s_valid, s_data,
                    input  s_ready, conv_valid, conv_data, tag_valid, tag_ch, busy);
    modport slave  (input  s_valid, s_data,
                    output s_ready, conv_valid, conv_data, tag_valid, tag_ch, busy);
endinterface

// File: rtl/width_8to12_sched_rr_arb.sv
// Combinational round-robin pick among NUM_CH requests starting at ptr.
module rr_arb_nch
    import width_conv_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic              any,
    output logic [CH_W-1:0]   pick
);
    logic [MAX_CH-1:0] req_x;

    assign req_x = MAX_CH'(req);
    assign any   = |req;
    assign pick  = CH_W'(rr_pick(req_x, IDX_W'(ptr), NUM_CH));
endmodule

// File: rtl/width_8to12_sched.sv
// Round-robin scheduler sharing one 8-to-12 converter between NUM_CH byte streams;
// grants move only on triplet boundaries and each converter word gets a channel tag.
module width_8to12_sched
    import width_conv_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int BURST  = 4,
    parameter int CH_W   = 2
) (
    input logic clk,
    input logic rst_n,
    width_8to12_sched_if.slave bus
);
    localparam logic [3:0] BURST_C = 4'(BURST);

    state_t                  state, state_nxt;
    logic [1:0]              phase, phase_nxt;
    logic [3:0]              trip_cnt, trip_nxt;
    logic [CH_W-1:0]         rr_ptr, rr_ptr_nxt, gnt, gnt_nxt, arb_pick;
    logic                    arb_any, sel_valid, xfer;
    logic [7:0]              sel_data;
    logic [1:0]              vld_pipe;
    logic [1:0][CH_W-1:0]    ch_pipe;

    rr_arb_nch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
        .req  (bus.s_valid),
        .ptr  (rr_ptr),
        .any  (arb_any),
        .pick (arb_pick)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt == CH_W'(i)) begin
                sel_valid = bus.s_valid[i];
                sel_data  = bus.s_data[i];
            end
        end
    end

    assign xfer        = (state == GRANT) && sel_valid;
    assign bus.s_ready = (state == GRANT) ? (NUM_CH'(1) << gnt) : '0;
    assign bus.busy    = (state == GRANT);

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        rr_ptr_nxt = rr_ptr;
        phase_nxt  = phase;
        trip_nxt   = trip_cnt;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    gnt_nxt   = arb_pick;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    if (phase == PHASE_LAST) begin
                        phase_nxt = 2'd0;
                        trip_nxt  = trip_cnt + 4'd1;
                    end else begin
                        phase_nxt = phase + 2'd1;
                    end
                end
                // Release only on a triplet boundary so the converter phase stays aligned.
                if (phase_nxt == 2'd0 && (!sel_valid || trip_nxt == BURST_C)) begin
                    state_nxt  = IDLE;
                    trip_nxt   = 4'd0;
                    rr_ptr_nxt = (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            phase          <= 2'd0;
            trip_cnt       <= 4'd0;
            rr_ptr         <= '0;
            gnt            <= '0;
            bus.conv_valid <= 1'b0;
            bus.conv_data  <= 8'd0;
            vld_pipe       <= 2'b00;
            ch_pipe        <= '0;
        end else begin
            state          <= state_nxt;
            phase          <= phase_nxt;
            trip_cnt       <= trip_nxt;
            rr_ptr         <= rr_ptr_nxt;
            gnt            <= gnt_nxt;
            bus.conv_valid <= xfer;
            if (xfer) bus.conv_data <= sel_data;
            // The converter emits a word after the 2nd and 3rd byte of each triplet.
            vld_pipe   <= {vld_pipe[0], xfer && (phase != 2'd0)};
            ch_pipe[0] <= gnt;
            if (vld_pipe[0]) ch_pipe[1] <= ch_pipe[0];
        end
    end

    assign bus.tag_valid = vld_pipe[1];
    assign bus.tag_ch    = ch_pipe[1];
endmodule

// File: tb/tb_width_8to12_sched.sv
// Directed plus random bench: per-channel byte queues feed the scheduler, a small
// transaction model predicts grants/latencies, and a converter model checks tag alignment.
module tb_width_8to12_sched;
    localparam int NUM_CH = 4;
    localparam int BURST  = 2;
    localparam int CH_W   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    width_8to12_sched_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

    width_8to12_sched #(.NUM_CH(NUM_CH), .BURST(BURST), .CH_W(CH_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural 8-to-12 converter downstream of the scheduler.
    logic [1:0]  cv_ph = 2'd0;
    logic [7:0]  cv_b0 = 8'd0;
    logic [3:0]  cv_b1 = 4'd0;
    logic        cv_wv = 1'b0;
    logic [11:0] cv_w  = 12'd0;
    always @(posedge clk) begin
        if (!rst_n) begin
            cv_ph <= 2'd0;
            cv_wv <= 1'b0;
        end else begin
            cv_wv <= 1'b0;
            if (bus.conv_valid) begin
                case (cv_ph)
                    2'd0: begin cv_b0 <= bus.conv_data; cv_ph <= 2'd1; end
                    2'd1: begin
                        cv_w  <= {cv_b0, bus.conv_data[7:4]};
                        cv_b1 <= bus.conv_data[3:0];
                        cv_wv <= 1'b1;
                        cv_ph <= 2'd2;
                    end
                    default: begin
                        cv_w  <= {cv_b1, bus.conv_data};
                        cv_wv <= 1'b1;
                        cv_ph <= 2'd0;
                    end
                endcase
            end
        end
    end

    logic [7:0]        q [NUM_CH][$];
    logic [NUM_CH-1:0] en = '1;
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner (-1 = idle), bytes moved in this grant, rr pointer,
    // plus the expected registered outputs.
    int          m_owner = -1, m_bytes = 0, m_ptr = 0;
    logic        e_cv = 1'b0;
    logic [7:0]  e_cd = 8'd0;
    logic        p_v = 1'b0;
    int          p_ch = 0;
    logic [11:0] p_w = 12'd0;
    logic        e_tv = 1'b0;
    int          e_tc = 0;
    logic [11:0] e_w = 12'd0;
    logic [7:0]  m_b0 = 8'd0;
    logic [3:0]  m_b1 = 4'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic rst);
        logic [NUM_CH-1:0] v;
        logic              xf, found;
        logic [7:0]        b;
        int                k, c;
        @(negedge clk);
        rst_n = !rst;
        for (int i = 0; i < NUM_CH; i++) begin
            v[i] = en[i] && (q[i].size() > 0);
            bus.s_data[i] = (q[i].size() > 0) ? q[i][0] : 8'h00;
        end
        bus.s_valid = v;
        #1;
        chk("s_ready", 32'(bus.s_ready), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
        chk("conv_valid", 32'(bus.conv_valid), 32'(e_cv));
        chk("conv_data", 32'(bus.conv_data), 32'(e_cd));
        chk("tag_valid", 32'(bus.tag_valid), 32'(e_tv));
        chk("tag_ch", 32'(bus.tag_ch), 32'(e_tc));
        chk("word_valid", 32'(cv_wv), 32'(e_tv));
        if (e_tv) chk("word", 32'(cv_w), 32'(e_w));

        xf = (m_owner >= 0) && v[m_owner];
        b  = xf ? q[m_owner][0] : 8'h00;
        if (xf) void'(q[m_owner].pop_front());
        if (rst) begin
            m_owner = -1; m_bytes = 0; m_ptr = 0;
            e_cv = 1'b0; e_cd = 8'd0; p_v = 1'b0; e_tv = 1'b0; e_tc = 0;
        end else begin
            e_cv = xf;
            if (xf) e_cd = b;
            e_tv = p_v;
            if (p_v) begin e_tc = p_ch; e_w = p_w; end
            k    = m_bytes % 3;
            p_v  = xf && (k != 0);
            p_ch = m_owner;
            if (xf) begin
                if (k == 0) m_b0 = b;
                else if (k == 1) begin p_w = {m_b0, b[7:4]}; m_b1 = b[3:0]; end
                else p_w = {m_b1, b};
            end
            if (m_owner < 0) begin
                found = 1'b0;
                for (int o = 0; o < NUM_CH; o++) begin
                    c = (m_ptr + o) % NUM_CH;
                    if (!found && v[c]) begin m_owner = c; found = 1'b1; end
                end
            end else begin
                if (xf) m_bytes++;
                if (m_bytes % 3 == 0 && (!v[m_owner] || m_bytes / 3 == BURST)) begin
                    m_ptr   = (m_owner + 1) % NUM_CH;
                    m_owner = -1;
                    m_bytes = 0;
                end
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b0);
    endtask

    task automatic push(input int ch, input int n);
        repeat (n) q[ch].push_back(8'($urandom));
    endtask

    initial begin
        bus.s_valid = '0;
        bus.s_data  = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        cycle(1'b1);
        run(1);

        // single channel, known bytes -> words 0xABC, 0xDEF
        q[0].push_back(8'hAB); q[0].push_back(8'hCD); q[0].push_back(8'hEF);
        run(10);

        // two channels contending
        push(0, 6); push(1, 6);
        run(24);

        // mid-triplet stall on ch0 while ch1 waits
        q[0].push_back(8'h11); q[0].push_back(8'h22);
        run(1);
        push(1, 3);
        run(6);
        q[0].push_back(8'h33);
        run(14);

        // burst limit: ch1 long stream, ch0 waiting
        push(1, 9);
        run(1);
        push(0, 3);
        run(24);

        // reset at phase 1, then a fresh triplet
        push(2, 3);
        run(2);
        cycle(1'b1);
        q[2].delete();
        push(2, 3);
        run(10);

        // rr pointer now 3: ch3 before ch0
        push(3, 3); push(0, 3);
        run(16);

        // random traffic with stalls and rare resets
        repeat (500) begin
            if ($urandom_range(0, 3) == 0) push($urandom_range(0, NUM_CH - 1), $urandom_range(1, 5));
            for (int i = 0; i < NUM_CH; i++) en[i] = ($urandom_range(0, 4) != 0);
            cycle($urandom_range(0, 99) == 0);
        end
        en = '1;
        run(150);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
